// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types for the bit-serial ALU slice:
//   alu_op_e    - 3-bit opcode (ADD, SUB, NOTA, NOTB, AND, OR, two reserved codes)
//   seq_state_e - sequencer FSM states (IDLE, SHIFT, DONE)
//   ALU_OP_W    - opcode width in bits
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_NOTA = 3'd2,
    OP_NOTB = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice
// Combinational 1-bit ALU slice.
//   x, y   - operand bits
//   c      - incoming carry (ADD) or borrow (SUB)
//   op     - opcode
//   r      - result bit
//   c_next - outgoing carry/borrow; passes c through for logic ops,
//            forced to 0 for reserved opcodes
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic    x,
  input  logic    y,
  input  logic    c,
  input  alu_op_e op,
  output logic    r,
  output logic    c_next
);

  always_comb begin
    r      = 1'b0;
    c_next = c;
    case (op)
      OP_ADD: begin
        r      = x ^ y ^ c;
        c_next = (x & y) | ((x ^ y) & c);
      end
      OP_SUB: begin
        // borrow out when y (plus incoming borrow) exceeds x
        r      = x ^ y ^ c;
        c_next = (~x & y) | (~(x ^ y) & c);
      end
      OP_NOTA: r = ~x;
      OP_NOTB: r = ~y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      default: begin
        r      = 1'b0;
        c_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq
// Bit-serial ALU sequencer: accepts WIDTH-bit operands and an opcode,
// feeds one bit per cycle (LSB first) through a single alu_bit_slice,
// holds the carry/borrow between bits, and presents the WIDTH-bit result
// plus final carry/borrow over a valid/ready output handshake.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid, in_ready   - operand handshake (in_ready high only in IDLE)
//   op, a, b             - opcode and unsigned operands
//   out_valid, out_ready - result handshake (out_valid high in DONE)
//   result, carry_out    - result word; carry (ADD) or borrow (SUB), else 0
//   busy                 - high while an operation is in SHIFT or DONE
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                carry_out,
  output logic                busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  seq_state_e       state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt;
  logic             c_q;
  logic             carry_q;
  logic             slice_r;
  logic             slice_c_next;
  logic             is_arith;

  alu_bit_slice u_slice (
    .x      (a_sr[0]),
    .y      (b_sr[0]),
    .c      (c_q),
    .op     (op_q),
    .r      (slice_r),
    .c_next (slice_c_next)
  );

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  // Handshake flags decode straight from the state register; in_ready is
  // additionally masked by rst so nothing is accepted during reset.
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign result    = res_q;
  assign carry_out = carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      a_sr    <= '0;
      b_sr    <= '0;
      res_q   <= '0;
      cnt     <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= alu_op_e'(op);
            a_sr    <= a;
            b_sr    <= b;
            cnt     <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // result fills from the MSB so bit 0 lands in place after WIDTH shifts
          res_q <= {slice_r, res_q[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          c_q   <= slice_c_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            carry_q <= is_arith ? slice_c_next : 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
